i2c_reg_target: RTL and testbench

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

---
 rtl/i2c_reg_target.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C write/read target with an 8-bit auto-incrementing pointer into a 256 x 8 register file.
// SCL/SDA are oversampled on audio_clk; SDA is only ever pulled low, never driven high.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | not addressed; waiting for START
//  DEVADDR   | shifting in device address + R/W bit
//  ACK_DEV   | ACK slot for the device address
//  SUBH      | shifting in the upper subaddress byte
//  ACK_SUBH  | ACK slot for the upper subaddress byte
//  SUBL      | shifting in the register pointer
//  ACK_SUBL  | ACK slot for the register pointer
//  WDATA     | shifting in a write data byte
//  ACK_WDATA | ACK slot for a write data byte
//  RDATA     | shifting out regfile[pointer]
//  MACK      | master ACK/NACK slot after a read byte
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR  = 7'b0111011,
    parameter logic [7:0] SUBADDR_H = 8'b0100_0000
) (
    input  logic       audio_clk,
    input  logic       reset,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_oe,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       error
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, SUBH, ACK_SUBH, SUBL, ACK_SUBL,
        WDATA, ACK_WDATA, RDATA, MACK
    } state_t;

    state_t     state_q, state_d;
    logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
    logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] pointer_q, pointer_d;
    logic       rw_q, rw_d;
    logic       wr_block_q, wr_block_d;
    logic       sda_oe_q, sda_oe_d;
    logic       reg_wr_q, reg_wr_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       busy_q, busy_d;
    logic       error_q, error_d;
    logic [7:0] mem_q [256];

    logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0] byte_in, ptr_inc;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign byte_done = (bit_cnt_q == 3'd7);
    assign byte_in   = {shift_q[6:0], sda_s2_q};
    assign ptr_inc   = pointer_q + 8'd1;

    always_comb begin
        scl_s1_d    = SCL;
        scl_s2_d    = scl_s1_q;
        scl_prev_d  = scl_s2_q;
        sda_s1_d    = SDA_in;
        sda_s2_d    = sda_s1_q;
        sda_prev_d  = sda_s2_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pointer_d   = pointer_q;
        rw_d        = rw_q;
        wr_block_d  = wr_block_q;
        sda_oe_d    = sda_oe_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        busy_d      = busy_q;
        error_d     = error_q;

        // START/STOP only occur with SCL high, so they never coincide with an SCL edge.
        if (start_det) begin
            state_d   = DEVADDR;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            busy_d     = 1'b0;
            wr_block_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                DEVADDR: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            state_d = ACK_DEV;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                SUBH: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d = ACK_SUBH;
                        if (byte_in != SUBADDR_H) begin
                            error_d    = 1'b1;
                            wr_block_d = 1'b1;
                        end
                    end
                end
                SUBL: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d   = ACK_SUBL;
                        pointer_d = byte_in;
                    end
                end
                WDATA: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d = ACK_WDATA;
                        if (!wr_block_q) begin
                            reg_wr_d    = 1'b1;
                            reg_addr_d  = pointer_q;
                            reg_wdata_d = byte_in;
                            pointer_d   = ptr_inc;
                        end
                    end
                end
                ACK_DEV: begin
                    if (rw_q) begin
                        state_d = RDATA;
                        shift_d = mem_q[pointer_q];
                    end else begin
                        state_d = SUBH;
                    end
                end
                ACK_SUBH:  state_d = SUBL;
                ACK_SUBL:  state_d = WDATA;
                ACK_WDATA: state_d = WDATA;
                RDATA: begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        state_d = MACK;
                    end
                end
                MACK: begin
                    if (!sda_s2_q) begin
                        state_d   = RDATA;
                        pointer_d = ptr_inc;
                        shift_d   = mem_q[ptr_inc];
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (scl_fall) begin
            // The registered drive lands one cycle after the synchronized falling edge.
            case (state_q)
                ACK_DEV, ACK_SUBH, ACK_SUBL, ACK_WDATA: sda_oe_d = 1'b1;
                RDATA:                                  sda_oe_d = ~shift_q[7];
                default:                                sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            pointer_q   <= 8'd0;
            rw_q        <= 1'b0;
            wr_block_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            scl_prev_q  <= scl_prev_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pointer_q   <= pointer_d;
            rw_q        <= rw_d;
            wr_block_q  <= wr_block_d;
            sda_oe_q    <= sda_oe_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    // Register file contents survive reset.
    always_ff @(posedge audio_clk) begin
        if (reg_wr_q) begin
            mem_q[reg_addr_q] <= reg_wdata_q;
        end
    end

    assign SDA_oe    = sda_oe_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign dbg_data  = mem_q[dbg_addr];
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged master on a wired-AND SDA line.
module tb_i2c_reg_target;
    localparam int Q = 8;

    logic       audio_clk = 1'b0;
    logic       reset     = 1'b1;
    logic       SCL       = 1'b1;
    logic       sda_m     = 1'b1;
    logic       SDA_in;
    logic       SDA_oe;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] dbg_addr  = 8'd0;
    logic [7:0] dbg_data;
    logic       busy;
    logic       error;

    int         n_cmp   = 0;
    int         n_err   = 0;
    int         oe_viol = 0;
    logic       oe_prev = 1'b0;
    logic       oe_seen = 1'b0;
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];

    i2c_reg_target dut (
        .audio_clk (audio_clk),
        .reset     (reset),
        .SCL       (SCL),
        .SDA_in    (SDA_in),
        .SDA_oe    (SDA_oe),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy),
        .error     (error)
    );

    always #5 audio_clk = ~audio_clk;
    assign SDA_in = sda_m & ~SDA_oe;

    // Log every reg_wr cycle, and flag any SDA_oe change while SCL is high.
    always @(negedge audio_clk) begin
        if (reg_wr) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
        end
        if (!reset && SCL && (SDA_oe !== oe_prev)) oe_viol++;
        oe_prev = SDA_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_present"}, 32'(wr_a.size() > idx), 32'd1);
        if (wr_a.size() > idx) begin
            chk({tag, "_addr"}, 32'(wr_a[idx]), 32'(a));
            chk({tag, "_data"}, 32'(wr_d[idx]), 32'(d));
        end
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] d);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(d));
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge audio_clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        SCL   = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_q();
        SCL   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        SCL   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        SCL   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b, output logic line);
        sda_m = b;    wait_q();
        SCL   = 1'b1; wait_q();
        line    = SDA_in;
        oe_seen = oe_seen | SDA_oe;
        wait_q();
        SCL   = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, inout int acks);
        logic l;
        for (int i = 7; i >= 0; i--) send_bit(b[i], l);
        send_bit(1'b1, l);
        if (l == 1'b0) acks++;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l);
            d[i] = l;
        end
        send_bit(mack, l);
    endtask

    task automatic write_txn(input logic [7:0] subh, input logic [7:0] ptr,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input int n, output int acks);
        acks = 0;
        bus_start();
        send_byte(8'h76, acks);
        send_byte(subh, acks);
        send_byte(ptr, acks);
        if (n > 0) send_byte(d0, acks);
        if (n > 1) send_byte(d1, acks);
        if (n > 2) send_byte(d2, acks);
        bus_stop();
    endtask

    initial begin
        int         acks;
        logic [7:0] rd;
        logic       l;

        repeat (4) @(negedge audio_clk);
        chk("rst_oe",    32'(SDA_oe),    32'd0);
        chk("rst_wr",    32'(reg_wr),    32'd0);
        chk("rst_addr",  32'(reg_addr),  32'd0);
        chk("rst_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        reset = 1'b0;
        wait_q();

        // Single write
        wr_a.delete(); wr_d.delete();
        acks = 0;
        bus_start();
        send_byte(8'h76, acks);
        send_byte(8'h40, acks);
        send_byte(8'h15, acks);
        send_byte(8'hA5, acks);
        chk("t1_busy_mid", 32'(busy), 32'd1);
        bus_stop();
        chk("t1_acks", 32'(acks), 32'd4);
        chk("t1_nwr", 32'(wr_a.size()), 32'd1);
        chk_wr("t1_wr0", 0, 8'h15, 8'hA5);
        chk_mem("t1_mem15", 8'h15, 8'hA5);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        write_txn(8'h40, 8'h16, 8'h3C, 8'h00, 8'h00, 1, acks);
        write_txn(8'h40, 8'h20, 8'h9A, 8'h00, 8'h00, 1, acks);
        write_txn(8'h40, 8'h30, 8'h5A, 8'h00, 8'h00, 1, acks);
        chk_mem("setup_mem30", 8'h30, 8'h5A);

        // Burst write across the pointer wrap
        wr_a.delete(); wr_d.delete();
        write_txn(8'h40, 8'hFE, 8'h11, 8'h22, 8'h33, 3, acks);
        chk("t2_acks", 32'(acks), 32'd6);
        chk("t2_nwr", 32'(wr_a.size()), 32'd3);
        chk_wr("t2_wr0", 0, 8'hFE, 8'h11);
        chk_wr("t2_wr1", 1, 8'hFF, 8'h22);
        chk_wr("t2_wr2", 2, 8'h00, 8'h33);
        chk_mem("t2_memFE", 8'hFE, 8'h11);
        chk_mem("t2_memFF", 8'hFF, 8'h22);
        chk_mem("t2_mem00", 8'h00, 8'h33);

        // Set pointer, repeated START, read two bytes
        wr_a.delete(); wr_d.delete();
        acks = 0;
        bus_start();
        send_byte(8'h76, acks);
        send_byte(8'h40, acks);
        send_byte(8'h15, acks);
        bus_rstart();
        send_byte(8'h77, acks);
        chk("t3_acks", 32'(acks), 32'd4);
        read_byte(1'b0, rd);
        chk("t3_rd0", 32'(rd), 32'hA5);
        read_byte(1'b1, rd);
        chk("t3_rd1", 32'(rd), 32'h3C);
        wait_q();
        chk("t3_oe_after_nack", 32'(SDA_oe), 32'd0);
        bus_stop();
        chk("t3_nwr", 32'(wr_a.size()), 32'd0);

        // Wrong device address
        acks = 0;
        bus_start();
        oe_seen = 1'b0;
        send_byte(8'h78, acks);
        chk("t4_acks", 32'(acks), 32'd0);
        chk("t4_oe_seen", 32'(oe_seen), 32'd0);
        chk("t4_busy_mid", 32'(busy), 32'd1);
        bus_stop();
        chk("t4_busy_end", 32'(busy), 32'd0);
        chk("t4_nwr", 32'(wr_a.size()), 32'd0);

        // Bad upper subaddress
        write_txn(8'h41, 8'h20, 8'h55, 8'h00, 8'h00, 1, acks);
        chk("t5_acks", 32'(acks), 32'd4);
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_nwr", 32'(wr_a.size()), 32'd0);
        chk_mem("t5_mem20", 8'h20, 8'h9A);

        // STOP after 4 bits of a data byte
        acks = 0;
        bus_start();
        send_byte(8'h76, acks);
        send_byte(8'h40, acks);
        send_byte(8'h30, acks);
        send_bit(1'b1, l);
        send_bit(1'b1, l);
        send_bit(1'b0, l);
        send_bit(1'b0, l);
        bus_stop();
        chk("t6_acks", 32'(acks), 32'd3);
        chk("t6_nwr", 32'(wr_a.size()), 32'd0);
        chk_mem("t6_mem30", 8'h30, 8'h5A);
        chk("t6_busy", 32'(busy), 32'd0);

        // Reset asserted during the device-address ACK
        acks = 0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'h76 >> i) & 8'h01) != 8'h00, l);
        sda_m = 1'b1; wait_q();
        SCL   = 1'b1; wait_q();
        chk("t7_ack_before_rst", 32'(SDA_oe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_oe_async", 32'(SDA_oe), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_error_cleared", 32'(error), 32'd0);
        repeat (4) @(negedge audio_clk);
        reset = 1'b0;
        wait_q();
        chk("t7_nwr", 32'(wr_a.size()), 32'd0);
        write_txn(8'h40, 8'h31, 8'h77, 8'h00, 8'h00, 1, acks);
        chk("t7_post_acks", 32'(acks), 32'd4);
        chk("t7_post_nwr", 32'(wr_a.size()), 32'd1);
        chk_wr("t7_post_wr0", 0, 8'h31, 8'h77);
        chk_mem("t7_mem31", 8'h31, 8'h77);

        chk("oe_while_scl_high", 32'(oe_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
